// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq
//   Turns single-transfer I2C commands (address, direction, 1..4 bytes) into
//   the control sequence of a byte-level I2C master. It reacts to the master's
//   status flags and returns one response per command: the read bytes and an
//   error code.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready high only when idle)
//   cmd_addr, cmd_rw       slave address byte, 0 = write / 1 = read
//   cmd_len, cmd_wdata     byte count (1..4), write bytes (byte 0 in [7:0])
//   rsp_valid              one-cycle response strobe
//   rsp_rdata, rsp_err     read bytes (byte k in [8k+7:8k]), 00 ok / 01 timeout / 10 bad length
//   i2c_begin, i2c_rw      start request and direction to the master
//   conti_write            more write bytes follow the current one
//   conti_receive          more read bytes are wanted after the current one
//   write_en, write_data   one-cycle write-byte strobe and data
//   slave_addr             address byte presented to the master
//   flag_start/stop        master status levels
//   flag_ack/nack, read_en master status events (acted on at their rising edge)
//   read_data              read byte, valid with the read_en rise
//
// State table
//   state           | meaning
//   S_IDLE          | ready for a command
//   S_BEGIN         | i2c_begin held high for BEGIN_CYCLES cycles
//   S_WAIT_START    | waiting for flag_start level
//   S_WAIT_ADDR_ACK | waiting for the address ACK
//   S_WR_LOAD       | present write byte i, pulse write_en
//   S_WR_WAIT       | waiting for ACK (more bytes) or NACK (last byte)
//   S_RD_WAIT       | capturing read bytes on read_en rises
//   S_WAIT_STOP     | waiting for flag_stop level
//   S_RESP          | issue rsp_valid, then back to idle

module i2c_cmd_seq #(
  parameter int BEGIN_CYCLES = 2,
  parameter int TIMEOUT      = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic        cmd_rw,
  input  logic [2:0]  cmd_len,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        i2c_begin,
  output logic        i2c_rw,
  output logic        conti_write,
  output logic        conti_receive,
  output logic        write_en,
  output logic [7:0]  slave_addr,
  output logic [7:0]  write_data,
  input  logic        flag_start,
  input  logic        flag_ack,
  input  logic        flag_nack,
  input  logic        flag_stop,
  input  logic        read_en,
  input  logic [7:0]  read_data
);

  // Timer is a down-counter that expires at zero; loading TIMEOUT-1 on entry
  // makes the timeout edge land exactly TIMEOUT cycles after the entry edge.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW = (BEGIN_CYCLES > 1) ? $clog2(BEGIN_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BEG_LOAD = BW'(BEGIN_CYCLES - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BADLEN  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BEGIN,
    S_WAIT_START,
    S_WAIT_ADDR_ACK,
    S_WR_LOAD,
    S_WR_WAIT,
    S_RD_WAIT,
    S_WAIT_STOP,
    S_RESP
  } state_t;

  state_t        state;
  logic [7:0]    addr_q;
  logic          rw_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [1:0]    idx;
  logic [1:0]    last_idx;
  logic [TW-1:0] tmr;
  logic [BW-1:0] beg_cnt;

  logic ack_q, nack_q, rden_q;
  logic ack_rise, nack_rise, rden_rise;
  logic in_wait;
  logic len_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      nack_q <= 1'b0;
      rden_q <= 1'b0;
    end else begin
      ack_q  <= flag_ack;
      nack_q <= flag_nack;
      rden_q <= read_en;
    end
  end

  assign ack_rise  = flag_ack  & ~ack_q;
  assign nack_rise = flag_nack & ~nack_q;
  assign rden_rise = read_en   & ~rden_q;

  assign in_wait = (state == S_WAIT_START)    || (state == S_WAIT_ADDR_ACK) ||
                   (state == S_WR_WAIT)       || (state == S_RD_WAIT)       ||
                   (state == S_WAIT_STOP);

  assign len_bad = (cmd_len == 3'd0) || (cmd_len > 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= ERR_OK;
      i2c_begin     <= 1'b0;
      i2c_rw        <= 1'b0;
      conti_write   <= 1'b0;
      conti_receive <= 1'b0;
      write_en      <= 1'b0;
      slave_addr    <= '0;
      write_data    <= '0;
      addr_q        <= '0;
      rw_q          <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      idx           <= '0;
      last_idx      <= '0;
      tmr           <= '0;
      beg_cnt       <= '0;
    end else begin
      // Strobes default low; the timer reloads whenever it is not counting,
      // which covers the reload on every state entry.
      write_en  <= 1'b0;
      rsp_valid <= 1'b0;
      tmr       <= TMR_LOAD;

      if (in_wait && (tmr == '0)) begin
        state         <= S_RESP;
        rsp_err       <= ERR_TIMEOUT;
        i2c_begin     <= 1'b0;
        conti_write   <= 1'b0;
        conti_receive <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_valid) begin
              cmd_ready <= 1'b0;
              addr_q    <= cmd_addr;
              rw_q      <= cmd_rw;
              wdata_q   <= cmd_wdata;
              rdata_q   <= '0;
              idx       <= '0;
              last_idx  <= 2'(cmd_len - 3'd1);
              if (len_bad) begin
                rsp_err <= ERR_BADLEN;
                state   <= S_RESP;
              end else begin
                i2c_rw        <= cmd_rw;
                conti_write   <= ~cmd_rw & (cmd_len > 3'd1);
                conti_receive <=  cmd_rw & (cmd_len > 3'd1);
                i2c_begin     <= 1'b1;
                beg_cnt       <= BEG_LOAD;
                state         <= S_BEGIN;
              end
            end
          end

          S_BEGIN: begin
            if (beg_cnt == '0) begin
              i2c_begin <= 1'b0;
              state     <= S_WAIT_START;
            end else begin
              beg_cnt <= beg_cnt - 1'b1;
            end
          end

          S_WAIT_START: begin
            if (flag_start) begin
              slave_addr <= addr_q;
              state      <= S_WAIT_ADDR_ACK;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end

          S_WAIT_ADDR_ACK: begin
            if (ack_rise) begin
              state <= rw_q ? S_RD_WAIT : S_WR_LOAD;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end

          S_WR_LOAD: begin
            write_data  <= wdata_q[{idx, 3'b000} +: 8];
            write_en    <= 1'b1;
            conti_write <= (idx != last_idx);
            state       <= S_WR_WAIT;
          end

          S_WR_WAIT: begin
            // A non-last byte only advances on ACK; the last byte only on NACK.
            if (idx != last_idx) begin
              if (ack_rise) begin
                idx   <= idx + 2'd1;
                state <= S_WR_LOAD;
              end else begin
                tmr <= tmr - 1'b1;
              end
            end else if (nack_rise) begin
              state <= S_WAIT_STOP;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end

          S_RD_WAIT: begin
            if (rden_rise) begin
              rdata_q[{idx, 3'b000} +: 8] <= read_data;
              if (idx == last_idx) begin
                state <= S_WAIT_STOP;
              end else begin
                idx <= idx + 2'd1;
                // Byte len-2 just landed: tell the master the next one is the last.
                if ((idx + 2'd1) == last_idx) begin
                  conti_receive <= 1'b0;
                end
              end
            end else begin
              tmr <= tmr - 1'b1;
            end
          end

          S_WAIT_STOP: begin
            if (flag_stop) begin
              rsp_err <= ERR_OK;
              state   <= S_RESP;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end

          S_RESP: begin
            rsp_valid     <= 1'b1;
            rsp_rdata     <= rdata_q;
            cmd_ready     <= 1'b1;
            conti_write   <= 1'b0;
            conti_receive <= 1'b0;
            i2c_begin     <= 1'b0;
            state         <= S_IDLE;
          end

          default: begin
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Bench for i2c_cmd_seq: directed transactions followed by randomized ones,
// with a behavioural master/slave model and expectations computed from the
// command fields.
module tb_i2c_cmd_seq;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_addr = '0;
  logic        cmd_rw = 1'b0;
  logic [2:0]  cmd_len = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        i2c_begin, i2c_rw, conti_write, conti_receive, write_en;
  logic [7:0]  slave_addr, write_data;
  logic        flag_start = 1'b0, flag_ack = 1'b0, flag_nack = 1'b0;
  logic        flag_stop = 1'b0, read_en = 1'b0;
  logic [7:0]  read_data = '0;

  always #5 clk = ~clk;

  i2c_cmd_seq #(.BEGIN_CYCLES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .i2c_begin(i2c_begin), .i2c_rw(i2c_rw), .conti_write(conti_write),
    .conti_receive(conti_receive), .write_en(write_en),
    .slave_addr(slave_addr), .write_data(write_data),
    .flag_start(flag_start), .flag_ack(flag_ack), .flag_nack(flag_nack),
    .flag_stop(flag_stop), .read_en(read_en), .read_data(read_data)
  );

  int total = 0;
  int bad = 0;

  // Cumulative observation counters, written only by the monitor.
  int         begin_hi = 0;
  int         rsp_cnt = 0;
  logic [7:0] wq[$];

  always @(negedge clk) begin
    if (i2c_begin) begin_hi++;
    if (rsp_valid) rsp_cnt++;
    if (write_en)  wq.push_back(write_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return 8'((w >> (8 * k)) & 32'hFF);
  endfunction

  // One full command against the master/slave model. With abort_wr set, the
  // task returns as soon as the first write byte is presented.
  task automatic run_cmd(input logic [7:0] a, input logic rw, input logic [2:0] len,
                         input logic [31:0] wd, input logic [31:0] rb, input bit abort_wr);
    int n, wb, bb, L;
    logic [31:0] exp_rd;
    L  = int'(len);
    wb = wq.size();
    bb = begin_hi;
    chk("ready_idle", cmd_ready, 1);
    cmd_addr = a; cmd_rw = rw; cmd_len = len; cmd_wdata = wd; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;

    if (L == 0 || L > 4) begin
      chk("badlen_rsp_early", rsp_valid, 0);
      tick();
      chk("badlen_rsp_valid", rsp_valid, 1);
      chk("badlen_err", rsp_err, 2'b10);
      chk("badlen_rdata", rsp_rdata, 0);
      tick();
      chk("badlen_rsp_pulse", rsp_valid, 0);
      chk("badlen_no_begin", begin_hi - bb, 0);
      chk("badlen_ready", cmd_ready, 1);
      return;
    end

    chk("busy_ready", cmd_ready, 0);
    chk("i2c_rw", i2c_rw, rw);
    chk("conti_w_init", conti_write, (!rw && L > 1));
    chk("conti_r_init", conti_receive, (rw && L > 1));
    n = 0;
    while (i2c_begin && n < 20) begin tick(); n++; end
    chk("begin_cycles", begin_hi - bb, 2);

    repeat ($urandom_range(0, 5)) tick();
    flag_start = 1'b1; tick(); flag_start = 1'b0;
    chk("slave_addr", slave_addr, a);
    repeat ($urandom_range(0, 4)) tick();
    flag_ack = 1'b1; tick(); flag_ack = 1'b0; tick();

    exp_rd = '0;
    if (!rw) begin
      for (int k = 0; k < L; k++) begin
        n = 0;
        while (!write_en && n < 20) begin tick(); n++; end
        chk("wen_seen", write_en, 1);
        chk("wdata", write_data, byte_of(wd, k));
        chk("conti_w", conti_write, (k < L - 1));
        if (abort_wr) return;
        repeat ($urandom_range(0, 4)) tick();
        if (k < L - 1) begin
          // read_en rising alongside the ACK is not for this state
          flag_ack = 1'b1; read_en = 1'b1; tick();
          flag_ack = 1'b0; read_en = 1'b0; tick();
        end else begin
          flag_nack = 1'b1; tick(); flag_nack = 1'b0; tick();
        end
      end
    end else begin
      for (int k = 0; k < L; k++) begin
        repeat ($urandom_range(0, 1)) tick();
        read_data = byte_of(rb, k);
        // flag_ack rising alongside read_en is not for this state
        read_en = 1'b1; flag_ack = 1'b1; tick();
        read_en = 1'b0; flag_ack = 1'b0; tick();
        chk("conti_r", conti_receive, (k < L - 2));
        exp_rd = exp_rd | (32'(byte_of(rb, k)) << (8 * k));
      end
    end

    repeat ($urandom_range(0, 5)) tick();
    flag_stop = 1'b1; tick(); flag_stop = 1'b0;
    chk("rsp_not_yet", rsp_valid, 0);
    tick();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err_ok", rsp_err, 2'b00);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("ready_after", cmd_ready, 1);
    chk("idle_conti", {conti_write, conti_receive, write_en}, 0);
    tick();
    chk("rsp_pulse", rsp_valid, 0);
    chk("rdata_hold", rsp_rdata, exp_rd);
    chk("wen_count", wq.size() - wb, rw ? 0 : L);
    if (!rw && (wq.size() - wb) == L) begin
      for (int k = 0; k < L; k++) chk("wbyte_order", wq[wb + k], byte_of(wd, k));
    end
  endtask

  initial begin
    #(TMO * 100000);
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a;
    logic        rw;
    logic [2:0]  len;
    logic [31:0] wd, rb;
    int          rc;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outs", {rsp_valid, i2c_begin, i2c_rw, conti_write, conti_receive, write_en}, 0);
    chk("rst_addr_data", {slave_addr, write_data, 14'd0, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    run_cmd(8'hA0, 1'b0, 3'd1, 32'h0000_005A, 32'h0, 1'b0);
    run_cmd(8'h50, 1'b0, 3'd3, 32'h0033_2211, 32'h0, 1'b0);
    run_cmd(8'hA1, 1'b1, 3'd2, 32'h0, 32'h0000_7EC3, 1'b0);
    run_cmd(8'h10, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 1'b0);
    run_cmd(8'h11, 1'b1, 3'd5, 32'h0, 32'h0, 1'b0);
    run_cmd(8'hA1, 1'b1, 3'd4, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Timeout: flag_start never arrives.
    cmd_addr = 8'h3C; cmd_rw = 1'b0; cmd_len = 3'd3; cmd_wdata = 32'h0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rc = 0;
    while (i2c_begin && rc < 20) begin tick(); rc++; end
    repeat (TMO - 1) tick();
    chk("tmo_err_before", rsp_err, 2'b00);
    chk("tmo_conti_before", conti_write, 1);
    chk("tmo_busy_before", cmd_ready, 0);
    tick();
    chk("tmo_err", rsp_err, 2'b01);
    chk("tmo_cleared", {i2c_begin, conti_write, conti_receive, write_en, rsp_valid}, 0);
    tick();
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_ready", cmd_ready, 1);
    tick();

    // Reset while waiting for a write ACK.
    run_cmd(8'h42, 1'b0, 3'd2, 32'h0000_BB99, 32'h0, 1'b1);
    rc = rsp_cnt;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", cmd_ready, 1);
    chk("arst_outs", {rsp_valid, i2c_begin, i2c_rw, conti_write, conti_receive, write_en}, 0);
    chk("arst_addr_data", {slave_addr, write_data}, 0);
    tick(); tick(); tick();
    chk("arst_no_rsp", rsp_cnt - rc, 0);
    rst_n = 1'b1;
    run_cmd(8'h42, 1'b0, 3'd2, 32'h0000_BB99, 32'h0, 1'b0);

    for (int it = 0; it < 14; it++) begin
      a  = 8'($urandom);
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) len = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(5, 7));
      else len = 3'($urandom_range(1, 4));
      wd = $urandom;
      rb = $urandom;
      run_cmd(a, rw, len, wd, rb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
